// File: rtl/mcu_link_pkg.sv
// Shared opcodes, FSM state types and sizing helpers for the MCU command link.
package mcu_link_pkg;

  localparam logic [7:0] CMD_GETCFG  = 8'd1;
  localparam logic [7:0] CMD_SETCFG  = 8'd2;
  localparam logic [7:0] CMD_OVERLAY = 8'd3;
  localparam logic [7:0] CMD_CURSOR  = 8'd4;
  localparam logic [7:0] CMD_TEXT    = 8'd5;
  localparam logic [7:0] CMD_ROMLOAD = 8'd6;
  localparam logic [7:0] CMD_ROMDATA = 8'd7;
  localparam logic [7:0] CMD_STATUS  = 8'd8;

  localparam logic [7:0] RPT_JOY     = 8'd1;

  typedef enum logic [1:0] {RX_IDLE, RX_PARAM, RX_ROMDATA} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_REPORT, TX_STRING, TX_STATUS} tx_state_t;

  function automatic int ceil_bytes(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/mcu_link_if.sv
// Byte-stream interface between the MCU UART (master) and the command link (slave).
interface mcu_link_if;
  import mcu_link_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output rx_data, output rx_valid, output tx_ready,
                  input  tx_data, input  tx_valid);
  modport slave  (input  rx_data, input  rx_valid, input  tx_ready,
                  output tx_data, output tx_valid);

endinterface

// File: rtl/mcu_link_tx.sv
// Transmit side: joypad report timer, pending-request arbitration and frame serializer.
module mcu_link_tx
  import mcu_link_pkg::*;
#(
  parameter int FREQ      = 21_477_000,
  parameter int REPORT_HZ = 50,
  parameter int NJOY      = 2,
  parameter int JOY_W     = 12,
  parameter int STR_LEN   = 73,
  parameter logic [8*STR_LEN-1:0] CONF_STR = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NJOY*JOY_W-1:0] joy,
  input  logic [7:0]            err_cnt,
  input  logic [7:0]            rom_loading,
  input  logic                  str_req,
  input  logic                  status_req,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready
);

  localparam int JB         = ceil_bytes(JOY_W);
  localparam int RPT_BYTES  = 1 + NJOY * JB;
  localparam int RPT_PERIOD = FREQ / REPORT_HZ;
  localparam int TMR_W      = $clog2(RPT_PERIOD + 1);

  tx_state_t             tx_state, tx_next;
  logic [TMR_W-1:0]      rpt_tmr;
  logic [NJOY*JOY_W-1:0] joy_snap, rpt_frame;
  logic [NJOY*JB*8-1:0]  payload;
  logic                  rpt_pending, str_pending, stat_pending;
  logic [15:0]           idx;
  logic [7:0]            cur_byte;
  logic                  last_byte;

  // Each channel is zero-padded to whole bytes, channel 0 first on the wire.
  always_comb begin
    payload = '0;
    for (int ch = 0; ch < NJOY; ch++)
      payload[ch*JB*8 +: JOY_W] = rpt_frame[ch*JOY_W +: JOY_W];
  end

  always_comb begin
    tx_next   = tx_state;
    cur_byte  = 8'h00;
    last_byte = 1'b0;
    unique case (tx_state)
      TX_IDLE: begin
        if (rpt_pending)       tx_next = TX_REPORT;
        else if (str_pending)  tx_next = TX_STRING;
        else if (stat_pending) tx_next = TX_STATUS;
      end
      TX_REPORT: begin
        if (idx == 16'd0) cur_byte = RPT_JOY;
        else              cur_byte = payload[8*(int'(idx)-1) +: 8];
        last_byte = (idx == 16'(RPT_BYTES - 1));
      end
      TX_STRING: begin
        if (idx < 16'(STR_LEN)) cur_byte = CONF_STR[8*(STR_LEN-1-int'(idx)) +: 8];
        last_byte = (idx == 16'(STR_LEN));
      end
      TX_STATUS: begin
        if (idx == 16'd0)      cur_byte = CMD_STATUS;
        else if (idx == 16'd1) cur_byte = err_cnt;
        else                   cur_byte = rom_loading;
        last_byte = (idx == 16'd2);
      end
    endcase
    if (tx_state != TX_IDLE && tx_valid && tx_ready && last_byte)
      tx_next = TX_IDLE;
  end

  // A bubble cycle follows every accepted byte, so tx_valid never depends on tx_ready combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      rpt_tmr      <= '0;
      joy_snap     <= '0;
      rpt_frame    <= '0;
      rpt_pending  <= 1'b0;
      str_pending  <= 1'b0;
      stat_pending <= 1'b0;
      idx          <= '0;
      tx_data      <= 8'h00;
      tx_valid     <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        idx <= '0;
        case (tx_next)
          TX_REPORT: begin
            rpt_pending <= 1'b0;
            rpt_frame   <= joy_snap;
          end
          TX_STRING: str_pending  <= 1'b0;
          TX_STATUS: stat_pending <= 1'b0;
          default: ;
        endcase
      end else if (!tx_valid) begin
        tx_data  <= cur_byte;
        tx_valid <= 1'b1;
      end else if (tx_ready) begin
        tx_valid <= 1'b0;
        idx      <= idx + 16'd1;
      end
      // New requests come after the clears so one arriving as its frame starts is not lost.
      if (str_req)    str_pending  <= 1'b1;
      if (status_req) stat_pending <= 1'b1;
      if (rpt_tmr == TMR_W'(RPT_PERIOD - 1)) begin
        rpt_tmr     <= '0;
        joy_snap    <= joy;
        rpt_pending <= 1'b1;
      end else begin
        rpt_tmr <= rpt_tmr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mcu_link.sv
// MCU command engine: decodes UART command bytes into core strobes and hands replies to mcu_link_tx.
module mcu_link
  import mcu_link_pkg::*;
#(
  parameter int FREQ        = 21_477_000,
  parameter int REPORT_HZ   = 50,
  parameter int NJOY        = 2,
  parameter int JOY_W       = 12,
  parameter int CFG_W       = 32,
  parameter int TEXT_COLS   = 32,
  parameter int TIMEOUT_CYC = FREQ / 100,
  parameter int STR_LEN     = 73,
  parameter logic [8*STR_LEN-1:0] CONF_STR =
    "MCU_LINK;;O1,Aspect ratio,4:3,16:9;O2,Scanlines,Off,On;T0,Reset;V,v2.0.10"
) (
  input  logic                  clk,
  input  logic                  reset,
  mcu_link_if.slave             link,
  input  logic [NJOY*JOY_W-1:0] joy,
  output logic                  overlay,
  output logic [CFG_W-1:0]      core_config,
  output logic [7:0]            rom_loading,
  output logic [7:0]            rom_do,
  output logic                  rom_do_valid,
  output logic [7:0]            x_wr,
  output logic [7:0]            y_wr,
  output logic [7:0]            char_wr,
  output logic                  we,
  output logic [7:0]            err_cnt
);

  localparam int CFG_BYTES = CFG_W / 8;
  localparam int TMO_W     = $clog2(TIMEOUT_CYC + 1);

  rx_state_t        rx_state, rx_next;
  logic [7:0]       cmd;
  logic [7:0]       param_idx;
  logic [CFG_W-1:0] cfg_shift, cfg_next;
  logic [23:0]      rom_len;
  logic [7:0]       cursor_x, cursor_y;
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_hit, param_last, timeout, bad_op;
  logic             str_req, status_req;
  logic [7:0]       tx_data_w;
  logic             tx_valid_w;

  assign cfg_next = CFG_W'({cfg_shift, link.rx_data});
  assign tmo_hit  = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  always_comb begin
    rx_next    = rx_state;
    param_last = 1'b0;
    timeout    = 1'b0;
    bad_op     = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (link.rx_valid) begin
          case (link.rx_data)
            CMD_GETCFG, CMD_STATUS: ;
            CMD_SETCFG, CMD_OVERLAY, CMD_CURSOR, CMD_TEXT,
            CMD_ROMLOAD, CMD_ROMDATA: rx_next = RX_PARAM;
            default: bad_op = 1'b1;
          endcase
        end
      end
      RX_PARAM: begin
        if (link.rx_valid) begin
          case (cmd)
            CMD_SETCFG:  param_last = (param_idx == 8'(CFG_BYTES - 1));
            CMD_CURSOR:  param_last = (param_idx == 8'd1);
            CMD_TEXT:    param_last = (link.rx_data == 8'h00);
            CMD_ROMDATA: param_last = (param_idx == 8'd2);
            default:     param_last = 1'b1;
          endcase
          if (param_last)
            rx_next = (cmd == CMD_ROMDATA && {rom_len[15:0], link.rx_data} != 24'd0)
                      ? RX_ROMDATA : RX_IDLE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          rx_next = RX_IDLE;
        end
      end
      RX_ROMDATA: begin
        if (link.rx_valid) begin
          if (rom_len == 24'd1) rx_next = RX_IDLE;
        end else if (tmo_hit) begin
          timeout = 1'b1;
          rx_next = RX_IDLE;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // core_config only loads on the final byte, so an aborted SETCFG leaves it untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      cmd          <= 8'h00;
      param_idx    <= 8'h00;
      cfg_shift    <= '0;
      rom_len      <= 24'd0;
      cursor_x     <= 8'h00;
      cursor_y     <= 8'h00;
      tmo_cnt      <= '0;
      str_req      <= 1'b0;
      status_req   <= 1'b0;
      overlay      <= 1'b1;
      core_config  <= '0;
      rom_loading  <= 8'h00;
      rom_do       <= 8'h00;
      rom_do_valid <= 1'b0;
      x_wr         <= 8'h00;
      y_wr         <= 8'h00;
      char_wr      <= 8'h00;
      we           <= 1'b0;
      err_cnt      <= 8'h00;
    end else begin
      rx_state     <= rx_next;
      we           <= 1'b0;
      rom_do_valid <= 1'b0;
      str_req      <= 1'b0;
      status_req   <= 1'b0;
      if (rx_state == RX_IDLE || link.rx_valid) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + 1'b1;
      if ((bad_op || timeout) && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      case (rx_state)
        RX_IDLE: begin
          if (link.rx_valid) begin
            cmd        <= link.rx_data;
            param_idx  <= 8'h00;
            cfg_shift  <= '0;
            rom_len    <= 24'd0;
            str_req    <= (link.rx_data == CMD_GETCFG);
            status_req <= (link.rx_data == CMD_STATUS);
          end
        end
        RX_PARAM: begin
          if (link.rx_valid) begin
            param_idx <= param_idx + 8'd1;
            case (cmd)
              CMD_SETCFG: begin
                cfg_shift <= cfg_next;
                if (param_last) core_config <= cfg_next;
              end
              CMD_OVERLAY: overlay <= link.rx_data[0];
              CMD_CURSOR: begin
                if (param_idx == 8'h00) cursor_x <= link.rx_data;
                else                    cursor_y <= link.rx_data;
              end
              CMD_TEXT: begin
                if (link.rx_data != 8'h00 && cursor_x < 8'(TEXT_COLS)) begin
                  x_wr     <= cursor_x;
                  y_wr     <= cursor_y;
                  char_wr  <= link.rx_data;
                  we       <= 1'b1;
                  cursor_x <= cursor_x + 8'd1;
                end
              end
              CMD_ROMLOAD: rom_loading <= link.rx_data;
              CMD_ROMDATA: rom_len     <= {rom_len[15:0], link.rx_data};
              default: ;
            endcase
          end
        end
        RX_ROMDATA: begin
          if (link.rx_valid) begin
            rom_do       <= link.rx_data;
            rom_do_valid <= 1'b1;
            rom_len      <= rom_len - 24'd1;
          end
        end
        default: ;
      endcase
    end
  end

  mcu_link_tx #(
    .FREQ      (FREQ),
    .REPORT_HZ (REPORT_HZ),
    .NJOY      (NJOY),
    .JOY_W     (JOY_W),
    .STR_LEN   (STR_LEN),
    .CONF_STR  (CONF_STR)
  ) u_tx (
    .clk         (clk),
    .reset       (reset),
    .joy         (joy),
    .err_cnt     (err_cnt),
    .rom_loading (rom_loading),
    .str_req     (str_req),
    .status_req  (status_req),
    .tx_data     (tx_data_w),
    .tx_valid    (tx_valid_w),
    .tx_ready    (link.tx_ready)
  );

  assign link.tx_data  = tx_data_w;
  assign link.tx_valid = tx_valid_w;

endmodule
